// File: rtl/mips_pkg.sv
// mips_pkg: shared imem geometry and loader state encoding
package mips_pkg;
  localparam int BYTE_W = 8;
  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_DATA_W = 64;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;
  function automatic logic wants_byte(input logic [2:0] s);
    return s == S_LEN_LO || s == S_LEN_HI || s == S_DATA || s == S_CHECK;
  endfunction
endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: packs bytes little-endian into one instruction word
module imem_byte_packer
  import mips_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [BYTE_W-1:0] data,
  output logic [DATA_W-1:0] word,
  output logic              last
);
  localparam int BPW = DATA_W / BYTE_W;
  localparam int LW = BPW > 1 ? $clog2(BPW) : 1;
  logic [LW-1:0] lane;
  assign last = lane == LW'(BPW - 1);
  // lane k lands in word[8k+7:8k]; the lane index wraps after the top byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lane <= '0;
      word <= '0;
    end else if (clr) begin
      lane <= '0;
      word <= '0;
    end else if (load) begin
      word[int'(lane)*BYTE_W +: BYTE_W] <= data;
      lane <= last ? '0 : lane + LW'(1);
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length/payload/checksum frame into imem and releases the core on success
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_written
);
  logic [2:0] state, nxt;
  logic [15:0] len, cnt;
  logic [BYTE_W-1:0] chk;
  logic [DATA_W-1:0] pk_word, word_next;
  logic xfer, go, pk_last;
  assign xfer = in_valid && in_ready;
  assign go = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  imem_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (go),
    .load (xfer && state == S_DATA),
    .data (in_data),
    .word (pk_word),
    .last (pk_last)
  );
  // the word being completed this cycle: earlier lanes from the packer, top lane straight from the stream
  always_comb begin
    word_next = pk_word;
    word_next[DATA_W-BYTE_W +: BYTE_W] = in_data;
  end
  // frame sequencing
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) nxt = S_LEN_LO;
      S_LEN_LO: if (xfer) nxt = S_LEN_HI;
      S_LEN_HI: if (xfer) nxt = {in_data, len[7:0]} != 16'd0 ? S_DATA : S_CHECK;
      S_DATA:   if (xfer && pk_last) nxt = S_WRITE;
      S_WRITE:  nxt = cnt + 16'd1 == len ? S_CHECK : S_DATA;
      S_CHECK:  if (xfer) nxt = in_data == chk ? S_DONE : S_ERROR;
      default:  nxt = state;
    endcase
  end
  // state, handshake, write port, counters, checksum and status flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      in_ready <= 1'b0;
      mem_we <= 1'b0;
      mem_adr <= '0;
      mem_wdata <= '0;
      cpu_hold <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
      words_written <= '0;
      chk <= '0;
      len <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      in_ready <= wants_byte(nxt);
      mem_we <= nxt == S_WRITE;
      if (go) begin
        chk <= '0;
        words_written <= '0;
        cnt <= '0;
        done <= 1'b0;
        error <= 1'b0;
        cpu_hold <= 1'b1;
      end
      if (xfer && state != S_CHECK) chk <= chk ^ in_data;
      if (xfer && state == S_LEN_LO) len[7:0] <= in_data;
      if (xfer && state == S_LEN_HI) len[15:8] <= in_data;
      if (xfer && state == S_DATA && pk_last) begin
        mem_adr <= BASE_ADDR + words_written;
        mem_wdata <= word_next;
      end
      if (state == S_WRITE) begin
        words_written <= words_written + ADDR_W'(1);
        cnt <= cnt + 16'd1;
      end
      if (state == S_CHECK && nxt == S_DONE) begin
        done <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (state == S_CHECK && nxt == S_ERROR) error <= 1'b1;
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: frame-level checks of two loaders (base 0000 and FFFF) fed the same stream
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic rdy0, rdy1, we0, we1, hold0, hold1, done0, done1, err0, err1;
  logic [15:0] adr0, adr1, ww0, ww1;
  logic [63:0] wd0, wd1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [79:0] q0[$];
  logic [79:0] q1[$];

  typedef struct {
    int n;
    bit bad;
    bit gaps;
    bit poke;
    bit fixed;
    bit exp_done;
    bit exp_err;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(16), .DATA_W(64), .BASE_ADDR(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .mem_adr(adr0), .mem_wdata(wd0), .mem_we(we0), .cpu_hold(hold0),
    .done(done0), .error(err0), .words_written(ww0)
  );
  imem_loader #(.ADDR_W(16), .DATA_W(64), .BASE_ADDR(16'hFFFF)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .mem_adr(adr1), .mem_wdata(wd1), .mem_we(we1), .cpu_hold(hold1),
    .done(done1), .error(err1), .words_written(ww1)
  );

  always @(negedge clk) begin
    if (we0) q0.push_back({adr0, wd0});
    if (we1) q1.push_back({adr1, wd1});
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    while (!rdy0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rdy0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %0h", b);
    end else begin
      check("ready_match", rdy1, rdy0);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [63:0] exp_w[$];
    logic [15:0] nn;
    logic [7:0] ck, b;
    logic [63:0] w;
    nn = 16'(v.n);
    q0.delete();
    q1.delete();
    pulse_start();
    check("start_done", done0, 0);
    check("start_error", err0, 0);
    check("start_hold", hold0, 1);
    check("start_ww", ww0, 0);
    ck = nn[7:0] ^ nn[15:8];
    send(nn[7:0], v.gaps);
    send(nn[15:8], v.gaps);
    for (int i = 0; i < v.n; i++) begin
      w = '0;
      for (int k = 0; k < 8; k++) begin
        b = v.fixed ? 8'(16 * i + k + 1) : 8'($urandom);
        if (v.poke && k == 3) pulse_start();
        send(b, v.gaps);
        w |= 64'(b) << (8 * k);
        ck ^= b;
        if (k == 7) begin
          check("we_latency", we0, 1);
          check("adr_base0", adr0, 16'(i));
          check("adr_baseffff", adr1, 16'(16'hFFFF + i));
          check("wdata", wd0, w);
        end
      end
      exp_w.push_back(w);
    end
    check("hold_before_ck", hold0, 1);
    send(v.bad ? ck ^ 8'h01 : ck, v.gaps);
    check("done0", done0, v.exp_done);
    check("done1", done1, v.exp_done);
    check("error0", err0, v.exp_err);
    check("error1", err1, v.exp_err);
    check("hold0", hold0, !v.exp_done);
    check("hold1", hold1, !v.exp_done);
    check("ww0", ww0, nn);
    check("ww1", ww1, nn);
    check("we_idle", we0, 0);
    check("nwrites0", q0.size(), v.n);
    check("nwrites1", q1.size(), v.n);
    for (int i = 0; i < v.n && i < q0.size() && i < q1.size(); i++) begin
      check("write0", q0[i], {16'(i), exp_w[i]});
      check("write1", q1[i], {16'(16'hFFFF + i), exp_w[i]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{n: 2, bad: 1, gaps: 0, poke: 0, fixed: 1, exp_done: 0, exp_err: 1};
    tbl[1] = '{n: 0, bad: 0, gaps: 0, poke: 0, fixed: 0, exp_done: 1, exp_err: 0};
    tbl[2] = '{n: 2, bad: 0, gaps: 1, poke: 0, fixed: 1, exp_done: 1, exp_err: 0};
    tbl[3] = '{n: 3, bad: 0, gaps: 1, poke: 1, fixed: 0, exp_done: 1, exp_err: 0};
    tbl[4] = '{n: 5, bad: 1, gaps: 1, poke: 0, fixed: 0, exp_done: 0, exp_err: 1};
    tbl[5] = '{n: 1, bad: 0, gaps: 0, poke: 0, fixed: 0, exp_done: 1, exp_err: 0};
    tbl[6] = '{n: 4, bad: 0, gaps: 1, poke: 1, fixed: 0, exp_done: 1, exp_err: 0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hold", hold0, 1);
    check("rst_ready", rdy0, 0);
    check("rst_we", we0, 0);
    check("rst_done", done0, 0);
    check("rst_error", err0, 0);
    check("rst_ww", ww0, 0);
    run_frame('{n: 2, bad: 0, gaps: 0, poke: 0, fixed: 1, exp_done: 1, exp_err: 0});
    if (q0.size() >= 2) begin
      check("word0_const", q0[0], {16'h0000, 64'h0807060504030201});
      check("word1_const", q0[1], {16'h0001, 64'h1817161514131211});
    end
    foreach (tbl[i]) run_frame(tbl[i]);
    pulse_start();
    send(8'h02, 0);
    send(8'h00, 0);
    for (int k = 0; k < 11; k++) send(8'($urandom), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hold", hold0, 1);
    check("arst_ready", rdy0, 0);
    check("arst_we", we0, 0);
    check("arst_done", done0, 0);
    check("arst_error", err0, 0);
    check("arst_ww", ww0, 0);
    check("arst_adr", adr0, 0);
    check("arst_wdata", wd0, 0);
    check("arst_hold1", hold1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame('{n: 2, bad: 0, gaps: 1, poke: 0, fixed: 0, exp_done: 1, exp_err: 0});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
